// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: Moore FSM over a shared memory port, memory wait-state counter,
// retire strobe and illegal-opcode trap. Define CTRL_JALR_EN to add the JALR1/JALR2 path.

module aludec (
  input  logic       opb5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] aluop,
  output logic [2:0] alucontrol
);
  logic rtypesub;
  assign rtypesub = funct7b5 & opb5;

  always_comb begin
    alucontrol = 3'b000;
    case (aluop)
      2'b00: alucontrol = 3'b000;
      2'b01: alucontrol = 3'b001;
      default: begin
        case (funct3)
          3'b000:  alucontrol = rtypesub ? 3'b001 : 3'b000;
          3'b010:  alucontrol = 3'b101;
          3'b110:  alucontrol = 3'b011;
          3'b111:  alucontrol = 3'b010;
          default: alucontrol = 3'b000;
        endcase
      end
    endcase
  end
endmodule

// state    | meaning
// FETCH    | read instruction at PC, PC+4 into PC on last wait cycle
// DECODE   | register read, OldPC+imm into ALUOut
// MEMADR   | rs1+imm address for load/store
// MEMREAD  | data read at ALUOut
// MEMWB    | load data to register file (retire)
// MEMWRITE | data write at ALUOut (retire on last wait cycle)
// EXECR    | rs1 op rs2
// EXECI    | rs1 op imm
// ALUWB    | ALUOut to register file (retire)
// JAL      | PC <- ALUOut target, ALU computes OldPC+4
// BEQ      | compare, PC <- ALUOut when Zero (retire)
// JALR1    | ALUOut <- rs1+imm
// JALR2    | PC <- ALUOut, ALU computes OldPC+4
// TRAP     | unsupported opcode, held until reset
module multicycle_controller #(
  parameter int MEM_LAT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       InstrDone,
  output logic       Illegal
);
  localparam int CW = (MEM_LAT == 0) ? 1 : $clog2(MEM_LAT + 1);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
    EXECI, ALUWB, JAL, BEQ, JALR1, JALR2, TRAP
  } state_t;

  state_t state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic last;
  logic [1:0] aluop;
  logic branch, pcupdate, irwrite_s, memwrite_s, regwrite_s, done_s, illegal_s;

  assign last = (cnt == CW'(MEM_LAT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = '0;
    case (state)
      FETCH: begin
        if (last) state_next = DECODE;
        else      cnt_next   = cnt + 1'b1;
      end
      DECODE: begin
        case (op)
          7'b0000011, 7'b0100011: state_next = MEMADR;
          7'b0110011:             state_next = EXECR;
          7'b0010011:             state_next = EXECI;
          7'b1101111:             state_next = JAL;
          7'b1100011:             state_next = BEQ;
`ifdef CTRL_JALR_EN
          7'b1100111:             state_next = JALR1;
`endif
          default:                state_next = TRAP;
        endcase
      end
      MEMADR:   state_next = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD: begin
        if (last) state_next = MEMWB;
        else      cnt_next   = cnt + 1'b1;
      end
      MEMWB:    state_next = FETCH;
      MEMWRITE: begin
        if (last) state_next = FETCH;
        else      cnt_next   = cnt + 1'b1;
      end
      EXECR, EXECI: state_next = ALUWB;
      ALUWB:    state_next = FETCH;
      JAL:      state_next = ALUWB;
      BEQ:      state_next = FETCH;
`ifdef CTRL_JALR_EN
      JALR1:    state_next = JALR2;
      JALR2:    state_next = ALUWB;
`endif
      TRAP:     state_next = TRAP;
      default:  state_next = FETCH;
    endcase
  end

  always_comb begin
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    aluop      = 2'b00;
    branch     = 1'b0;
    pcupdate   = 1'b0;
    irwrite_s  = 1'b0;
    memwrite_s = 1'b0;
    regwrite_s = 1'b0;
    done_s     = 1'b0;
    illegal_s  = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        irwrite_s = last;
        pcupdate  = last;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc  = 2'b01;
        regwrite_s = 1'b1;
        done_s     = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc     = 1'b1;
        memwrite_s = last;
        done_s     = last;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        aluop   = 2'b10;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        aluop   = 2'b10;
      end
      ALUWB: begin
        regwrite_s = 1'b1;
        done_s     = 1'b1;
      end
`ifdef CTRL_JALR_EN
      JALR1: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      JALR2: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pcupdate = 1'b1;
      end
`endif
      JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pcupdate = 1'b1;
      end
      BEQ: begin
        ALUSrcA = 2'b10;
        aluop   = 2'b01;
        branch  = 1'b1;
        done_s  = 1'b1;
      end
      TRAP:    illegal_s = 1'b1;
      default: ;
    endcase
  end

  // Reset masks every strobe immediately so an aborted instruction cannot fire anything.
  assign PCWrite   = ~reset & ((branch & Zero) | pcupdate);
  assign IRWrite   = ~reset & irwrite_s;
  assign MemWrite  = ~reset & memwrite_s;
  assign RegWrite  = ~reset & regwrite_s;
  assign InstrDone = ~reset & done_s;
  assign Illegal   = ~reset & illegal_s;

  always_comb begin
    case (op)
      7'b0100011: ImmSrc = 2'b01;
      7'b1100011: ImmSrc = 2'b10;
      7'b1101111: ImmSrc = 2'b11;
      default:    ImmSrc = 2'b00;
    endcase
  end

  aludec u_aludec (
    .opb5      (op[5]),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .aluop     (aluop),
    .alucontrol(ALUControl)
  );
endmodule
